wb_queue: RTL and testbench
===========================

// Module: wb_queue
// PURPOSE
// Write-back stage directly upstream of the register file write port. Collects results
// from the ALU and the load unit (both may finish in the same cycle), buffers them in
// program order in a small FIFO, and drains one entry per cycle into wrAdd/wrData/wrEnable.
// Also reports, per read address, whether a write to that register is still queued.
// Decode uses this for hazard stalls.
// PARAMETERS
// DEPTH   4   FIFO entries; power of 2, >=2
// PTR_W   2   pointer width = log2(DEPTH)
// DATA_W  32  result width; must match register file data width
// PORTS
// clk        in   1       clock, all state on posedge
// rst        in   1       synchronous, active-high reset
// ld_valid   in   1       load result valid
// ld_rd      in   5       load destination register
// ld_data    in   DATA_W  load result
// ld_ready   out  1       load result accepted this cycle
// alu_valid  in   1       ALU result valid
// alu_rd     in   5       ALU destination register
// alu_data   in   DATA_W  ALU result
// alu_ready  out  1       ALU result accepted this cycle
// wr_hold    in   1       1 = do not drain this cycle (write port borrowed)
// wrAdd      out  5       to register file write address
// wrData     out  DATA_W  to register file write data
// wrEnable   out  1       to register file write enable
// rsAdd      in   5       hazard query address A
// rtAdd      in   5       hazard query address B
// rs_pend    out  1       queued write to rsAdd exists
// rt_pend    out  1       queued write to rtAdd exists
// count      out  PTR_W+1 occupied entries
// full       out  1       count == DEPTH
// empty      out  1       count == 0
// BEHAVIOUR
// - Reset: rd_ptr=wr_ptr=0, count=0. Entry valid bits cleared. Outputs after reset:
//   wrEnable=0, rs_pend=rt_pend=0, empty=1, full=0. Entry data is don't-care.
//   Reset wins over any push or drain in the same cycle. Queued writes are discarded.
// - Readiness: free = DEPTH-count, computed from count at start of cycle; a same-cycle pop
//   is not credited. ld_ready = (free>=1).
//   alu_ready = ld_valid ? (free>=2) : (free>=1).
//   Loads have priority; readiness does not depend on alu_valid.
// - Transfer occurs when valid&&ready. When both transfer in one cycle, the load entry is
//   written at wr_ptr and the ALU entry at wr_ptr+1. Ordering is load then ALU.
// - A transfer with rd==0 completes the handshake but stores nothing. It has no effect on
//   count. Register 0 is never written.
// - Drain (comb outputs): wrEnable = !empty && !wr_hold. wrAdd/wrData = head entry.
//   wrAdd/wrData are 0 when empty. A drain pops the head at the same edge.
// - Latency: a result accepted at edge N is written at edge N+1 at the earliest
//   (empty, no hold). Throughput is 1 write per cycle.
// - count_next = count + pushes(0..2) - pop(0..1). Never exceeds DEPTH by construction.
//   Pointers wrap modulo DEPTH. Push and pop in the same cycle are legal at any occupancy.
// - Hazard: rs_pend = (rsAdd!=0) && any valid entry with rd==rsAdd.
//   rt_pend works the same on rtAdd. Same-cycle incoming results are not included.
//   The head being drained this cycle still counts as pending.
// - No state machine beyond the FIFO. No value is lost or reordered under any mix of
//   hold, push and pop.
// TESTING
// T1 empty, same cycle ld(rd=5,0xAAAA_0000)+alu(rd=6,0x0000_1234) -> both ready; next cycle
//    wrEnable=1 wrAdd=5 wrData=0xAAAA_0000, following cycle wrAdd=6 wrData=0x0000_1234.
// T2 wr_hold=1, push 4 ALU results rd=1..4 -> full=1, ld_ready=alu_ready=0,
//    count=4; drop hold -> writes rd=1,2,3,4 on 4 consecutive cycles, then empty=1.
// T3 count=3, ld_valid&alu_valid -> ld_ready=1, alu_ready=0; only load stored, count=4.
// T4 push alu rd=0 data=0xFFFF_FFFF -> alu_ready=1, count stays 0, wrEnable never 1.
// T5 hold, push rd=7; rsAdd=7,rtAdd=8 -> rs_pend=1, rt_pend=0; rsAdd=0 -> rs_pend=0;
//    release -> rs_pend=0 on the cycle after the write.
// T6 DEPTH=4, queue 3 entries, pulse rst 1 cycle -> next cycle count=0, wrEnable=0.
//    Then stream 10 results at alternating 1/2 per cycle -> in-order writes across
//    pointer wrap.

Source files
------------

// File: rtl/wb_queue_if.sv
// Write-back queue bundle: producer handshakes, register-file write port, hazard query and status.
// slave faces the queue; master faces the producers, the register file and decode.
interface wb_queue_if #(
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              wr_hold;
  logic [4:0]        wrAdd;
  logic [DATA_W-1:0] wrData;
  logic              wrEnable;
  logic [4:0]        rsAdd;
  logic [4:0]        rtAdd;
  logic              rs_pend;
  logic              rt_pend;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wr_hold, rsAdd, rtAdd,
    output ld_ready, alu_ready, wrAdd, wrData, wrEnable, rs_pend, rt_pend, count, full, empty
  );

  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wr_hold, rsAdd, rtAdd,
    input  ld_ready, alu_ready, wrAdd, wrData, wrEnable, rs_pend, rt_pend, count, full, empty
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO (load before ALU) draining one entry per cycle; earliest write one edge after accept.
// Readiness comes from start-of-cycle occupancy only; a same-cycle drain is not credited; wr_hold stalls the drain.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  wb_queue_if.slave bus
);
  localparam int            CW      = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]     count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [4:0]        rd_q  [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];

  logic [CW-1:0]    free;
  logic             ld_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic             rs_hit;
  logic             rt_hit;

  assign free          = DEPTH_C - count_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = (count_q == DEPTH_C);
  assign bus.ld_ready  = (free >= CW'(1));
  assign bus.alu_ready = bus.ld_valid ? (free >= CW'(2)) : (free >= CW'(1));

  // rd==0 results finish the handshake but never occupy a slot
  assign ld_push  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != 5'd0);
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
  assign alu_slot = ld_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign pop      = !bus.empty && !bus.wr_hold;

  assign bus.wrEnable = pop;
  assign bus.wrAdd    = bus.empty ? '0 : rd_q[rd_ptr_q];
  assign bus.wrData   = bus.empty ? '0 : dat_q[rd_ptr_q];

  always_comb begin
    vld_d = vld_q;
    if (pop)      vld_d[rd_ptr_q] = 1'b0;
    if (ld_push)  vld_d[wr_ptr_q] = 1'b1;
    if (alu_push) vld_d[alu_slot] = 1'b1;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(ld_push) + PTR_W'(alu_push);
    count_d  = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
  end

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == bus.rsAdd)) rs_hit = 1'b1;
      if (vld_q[i] && (rd_q[i] == bus.rtAdd)) rt_hit = 1'b1;
    end
  end

  assign bus.rs_pend = (bus.rsAdd != 5'd0) && rs_hit;
  assign bus.rt_pend = (bus.rtAdd != 5'd0) && rt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Payload needs no reset: the valid bits and count gate every use of it
  always_ff @(posedge clk) begin
    if (ld_push) begin
      rd_q[wr_ptr_q]  <= bus.ld_rd;
      dat_q[wr_ptr_q] <= bus.ld_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]  <= bus.alu_rd;
      dat_q[alu_slot] <= bus.alu_data;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus a randomized run against a queue-based reference model.
module tb_wb_queue;
  logic clk;
  logic rst;

  wb_queue_if #(.PTR_W(2), .DATA_W(32)) bus ();

  wb_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   n_checks;
  int   n_fail;

  task automatic idle();
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = 5'd0;
    bus.ld_data   = 32'd0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.wr_hold   = 1'b0;
    bus.rsAdd     = 5'd0;
    bus.rtAdd     = 5'd0;
  endtask

  // Advance one clock and move the reference queue by the same rules.
  task automatic tick();
    int fr;
    bit ld_x;
    bit alu_x;
    bit pop_x;
    fr    = 4 - mq.size();
    ld_x  = bus.ld_valid && (fr >= 1);
    alu_x = bus.alu_valid && (bus.ld_valid ? (fr >= 2) : (fr >= 1));
    pop_x = (mq.size() > 0) && !bus.wr_hold;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (pop_x) void'(mq.pop_front());
      if (ld_x && bus.ld_rd != 5'd0)   mq.push_back('{rd: bus.ld_rd, d: bus.ld_data});
      if (alu_x && bus.alu_rd != 5'd0) mq.push_back('{rd: bus.alu_rd, d: bus.alu_data});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    bus.rsAdd = 5'd5;
    bus.rtAdd = 5'd6;
    #1;
    n_checks++; if (bus.count !== 3'd0)    begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0)     begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_checks++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", bus.wrEnable); end
    n_checks++; if (bus.wrAdd !== 5'd0)    begin n_fail++; $display("FAIL reset_wradd got %0d want 0", bus.wrAdd); end
    n_checks++; if ({bus.rs_pend, bus.rt_pend} !== 2'b00) begin n_fail++; $display("FAIL reset_pend got %b want 00", {bus.rs_pend, bus.rt_pend}); end
  endtask

  task automatic test_dual_push();
    idle();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 32'hAAAA_0000;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h0000_1234;
    #1;
    n_checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b11) begin n_fail++; $display("FAIL dual_ready got %b want 11", {bus.ld_ready, bus.alu_ready}); end
    tick();
    idle();
    #1;
    n_checks++; if (bus.wrEnable !== 1'b1)           begin n_fail++; $display("FAIL dual_wren0 got %b want 1", bus.wrEnable); end
    n_checks++; if (bus.wrAdd !== 5'd5)              begin n_fail++; $display("FAIL dual_add0 got %0d want 5", bus.wrAdd); end
    n_checks++; if (bus.wrData !== 32'hAAAA_0000)    begin n_fail++; $display("FAIL dual_dat0 got %h want aaaa0000", bus.wrData); end
    tick();
    n_checks++; if (bus.wrEnable !== 1'b1)           begin n_fail++; $display("FAIL dual_wren1 got %b want 1", bus.wrEnable); end
    n_checks++; if (bus.wrAdd !== 5'd6)              begin n_fail++; $display("FAIL dual_add1 got %0d want 6", bus.wrAdd); end
    n_checks++; if (bus.wrData !== 32'h0000_1234)    begin n_fail++; $display("FAIL dual_dat1 got %h want 00001234", bus.wrData); end
    tick();
    n_checks++; if (bus.empty !== 1'b1)              begin n_fail++; $display("FAIL dual_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full_hold();
    idle();
    bus.wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(i); bus.alu_data = 32'h100 + i;
      tick();
    end
    bus.alu_valid = 1'b0;
    #1;
    n_checks++; if (bus.full !== 1'b1)  begin n_fail++; $display("FAIL full_flag got %b want 1", bus.full); end
    n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", bus.count); end
    n_checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b00) begin n_fail++; $display("FAIL full_ready got %b want 00", {bus.ld_ready, bus.alu_ready}); end
    n_checks++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL full_hold_wren got %b want 0", bus.wrEnable); end
    bus.wr_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++; if (bus.wrEnable !== 1'b1) begin n_fail++; $display("FAIL drain_wren[%0d] got %b want 1", i, bus.wrEnable); end
      n_checks++; if (bus.wrAdd !== 5'(i))   begin n_fail++; $display("FAIL drain_add[%0d] got %0d want %0d", i, bus.wrAdd, i); end
      n_checks++; if (bus.wrData !== 32'h100 + i) begin n_fail++; $display("FAIL drain_dat[%0d] got %h want %h", i, bus.wrData, 32'h100 + i); end
      tick();
    end
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_priority();
    idle();
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(9 + i); bus.alu_data = 32'h900 + i;
      tick();
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_data = 32'hD00D_0012;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'hD00D_0013;
    #1;
    n_checks++; if ({bus.ld_ready, bus.alu_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_ready got %b want 10", {bus.ld_ready, bus.alu_ready}); end
    tick();
    idle();
    bus.wr_hold = 1'b1;
    #1;
    n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL prio_count got %0d want 4", bus.count); end
    bus.wr_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.wrAdd !== 5'(9 + i)) begin n_fail++; $display("FAIL prio_order[%0d] got %0d want %0d", i, bus.wrAdd, 9 + i); end
      tick();
    end
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL prio_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_rd_zero();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", bus.alu_ready); end
    tick();
    idle();
    #1;
    n_checks++; if (bus.count !== 3'd0)    begin n_fail++; $display("FAIL rd0_count got %0d want 0", bus.count); end
    n_checks++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL rd0_wren got %b want 0", bus.wrEnable); end
    tick();
    n_checks++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL rd0_wren_later got %b want 0", bus.wrEnable); end
  endtask

  task automatic test_hazard();
    idle();
    bus.wr_hold = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777;
    tick();
    bus.alu_valid = 1'b0;
    bus.rsAdd = 5'd7; bus.rtAdd = 5'd8;
    #1;
    n_checks++; if ({bus.rs_pend, bus.rt_pend} !== 2'b10) begin n_fail++; $display("FAIL haz_pend got %b want 10", {bus.rs_pend, bus.rt_pend}); end
    bus.rsAdd = 5'd0;
    #1;
    n_checks++; if (bus.rs_pend !== 1'b0) begin n_fail++; $display("FAIL haz_r0 got %b want 0", bus.rs_pend); end
    bus.rsAdd = 5'd7;
    bus.wr_hold = 1'b0;
    #1;
    n_checks++; if ({bus.wrEnable, bus.rs_pend} !== 2'b11) begin n_fail++; $display("FAIL haz_draining got %b want 11", {bus.wrEnable, bus.rs_pend}); end
    tick();
    n_checks++; if (bus.rs_pend !== 1'b0) begin n_fail++; $display("FAIL haz_after got %b want 0", bus.rs_pend); end
  endtask

  task automatic test_reset_wrap();
    logic [4:0]  exp_rd [10];
    logic [31:0] exp_d  [10];
    int idx;
    int nwr;
    int fr;
    bit two;
    idle();
    bus.wr_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = 32'h2000 + i;
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.count !== 3'd0)    begin n_fail++; $display("FAIL rstq_count got %0d want 0", bus.count); end
    n_checks++; if (bus.wrEnable !== 1'b0) begin n_fail++; $display("FAIL rstq_wren got %b want 0", bus.wrEnable); end
    for (int k = 0; k < 10; k++) begin
      exp_rd[k] = 5'(1 + k);
      exp_d[k]  = 32'hC0DE_0000 + k;
    end
    idx = 0;
    nwr = 0;
    two = 1'b0;
    for (int c = 0; c < 60 && nwr < 10; c++) begin
      idle();
      if (idx < 10) begin
        bus.ld_valid = 1'b1; bus.ld_rd = exp_rd[idx]; bus.ld_data = exp_d[idx];
      end
      if (two && idx + 1 < 10) begin
        bus.alu_valid = 1'b1; bus.alu_rd = exp_rd[idx + 1]; bus.alu_data = exp_d[idx + 1];
      end
      #1;
      fr = 4 - mq.size();
      if (bus.wrEnable === 1'b1) begin
        n_checks++;
        if (nwr >= 10 || bus.wrAdd !== exp_rd[nwr] || bus.wrData !== exp_d[nwr]) begin
          n_fail++; $display("FAIL wrap_write[%0d] got %0d/%h want %0d/%h", nwr, bus.wrAdd, bus.wrData, exp_rd[nwr % 10], exp_d[nwr % 10]);
        end
        nwr++;
      end
      if (bus.ld_valid && fr >= 1) idx++;
      if (bus.alu_valid && fr >= 2) idx++;
      two = ~two;
      tick();
    end
    idle();
    n_checks++; if (nwr !== 10) begin n_fail++; $display("FAIL wrap_total got %0d want 10", nwr); end
  endtask

  task automatic test_random();
    int fr;
    bit e_rs;
    bit e_rt;
    for (int c = 0; c < 500; c++) begin
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_rd     = 5'($urandom_range(0, 7));
      bus.ld_data   = $urandom;
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.wr_hold   = ($urandom_range(0, 3) == 0);
      bus.rsAdd     = 5'($urandom_range(0, 7));
      bus.rtAdd     = 5'($urandom_range(0, 7));
      #1;
      fr = 4 - mq.size();
      e_rs = 1'b0;
      e_rt = 1'b0;
      foreach (mq[j]) begin
        if (bus.rsAdd != 5'd0 && mq[j].rd == bus.rsAdd) e_rs = 1'b1;
        if (bus.rtAdd != 5'd0 && mq[j].rd == bus.rtAdd) e_rt = 1'b1;
      end
      n_checks++; if (bus.count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.count, mq.size()); end
      n_checks++; if ({bus.full, bus.empty} !== {fr == 0, fr == 4}) begin n_fail++; $display("FAIL rnd_flags c=%0d got %b want %b", c, {bus.full, bus.empty}, {fr == 0, fr == 4}); end
      n_checks++; if (bus.ld_ready !== (fr >= 1)) begin n_fail++; $display("FAIL rnd_ldrdy c=%0d got %b want %b", c, bus.ld_ready, fr >= 1); end
      n_checks++; if (bus.alu_ready !== (bus.ld_valid ? fr >= 2 : fr >= 1)) begin n_fail++; $display("FAIL rnd_alurdy c=%0d got %b free=%0d", c, bus.alu_ready, fr); end
      n_checks++; if (bus.wrEnable !== (fr < 4 && !bus.wr_hold)) begin n_fail++; $display("FAIL rnd_wren c=%0d got %b want %b", c, bus.wrEnable, fr < 4 && !bus.wr_hold); end
      if (mq.size() > 0) begin
        n_checks++; if (bus.wrAdd !== mq[0].rd || bus.wrData !== mq[0].d) begin n_fail++; $display("FAIL rnd_head c=%0d got %0d/%h want %0d/%h", c, bus.wrAdd, bus.wrData, mq[0].rd, mq[0].d); end
      end else begin
        n_checks++; if (bus.wrAdd !== 5'd0 || bus.wrData !== 32'd0) begin n_fail++; $display("FAIL rnd_head_empty c=%0d got %0d/%h want 0/0", c, bus.wrAdd, bus.wrData); end
      end
      n_checks++; if ({bus.rs_pend, bus.rt_pend} !== {e_rs, e_rt}) begin n_fail++; $display("FAIL rnd_pend c=%0d got %b want %b", c, {bus.rs_pend, bus.rt_pend}, {e_rs, e_rt}); end
      tick();
    end
    idle();
    for (int c = 0; c < 6; c++) tick();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rnd_final_empty got %b want 1", bus.empty); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_dual_push();
    test_full_hold();
    test_priority();
    test_rd_zero();
    test_hazard();
    test_reset_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
